// File: rtl/mem_bank_fsm_if.sv
// Command/status bundle between an upstream command source and one memory bank FSM.
interface mem_bank_fsm_if #(
  parameter int unsigned ADDRWIDTH = 17
);
  logic                 cmd_valid;
  logic [2:0]           cmd;
  logic [ADDRWIDTH-1:0] row;
  logic                 stall;
  logic                 cmd_ready;
  logic [4:0]           BankFSM;
  logic [ADDRWIDTH-1:0] RowId;
  logic                 sync;
  logic                 err;

  modport master (
    output cmd_valid, cmd, row, stall,
    input  cmd_ready, BankFSM, RowId, sync, err
  );

  modport slave (
    input  cmd_valid, cmd, row, stall,
    output cmd_ready, BankFSM, RowId, sync, err
  );
endinterface

// File: rtl/mem_bank_fsm.sv
// Single-bank DRAM command sequencer: ACT/RD/WR/PRE/REF timing, open-row tracking, row-change sync.
// Optional macro AUTOPRECHARGE_EN enables RDA/WRA (burst followed by automatic precharge).
module mem_bank_fsm #(
  parameter int unsigned ADDRWIDTH = 17,
  parameter int unsigned TRCD      = 4,
  parameter int unsigned TRP       = 4,
  parameter int unsigned TRFC      = 16,
  parameter int unsigned BURSTCYC  = 4
) (
  input logic            clk,
  input logic            reset_n,
  mem_bank_fsm_if.slave  bus
);

  localparam int unsigned TW = 8;

  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_ACT = 3'b001;
  localparam logic [2:0] CMD_RD  = 3'b010;
  localparam logic [2:0] CMD_WR  = 3'b011;
  localparam logic [2:0] CMD_PRE = 3'b100;
  localparam logic [2:0] CMD_REF = 3'b101;
  localparam logic [2:0] CMD_RDA = 3'b110;
  localparam logic [2:0] CMD_WRA = 3'b111;

  typedef enum logic [4:0] {
    IDLE        = 5'b00000,
    ACTIVATING  = 5'b00001,
    ACTIVE      = 5'b00010,
    PRECHARGING = 5'b00011,
    REFRESHING  = 5'b00100,
    READ        = 5'b01011,
    READDATA    = 5'b01100,
    WRITE       = 5'b10010,
    WRITEDATA   = 5'b10011
  } state_t;

  state_t               state;
  logic [TW-1:0]        timer;
  logic [ADDRWIDTH-1:0] row_id;
  logic                 row_valid;
  logic                 out_en;
  logic                 sync_q;
  logic                 err_q;
  logic                 accept;
`ifdef AUTOPRECHARGE_EN
  logic                 auto_pre;
`endif

  // Stall masks the pulses without consuming them, so a pending sync reappears once stall drops.
  assign bus.cmd_ready = out_en & ((state == IDLE) | (state == ACTIVE)) & ~bus.stall;
  assign bus.sync      = sync_q & ~bus.stall;
  assign bus.err       = err_q & ~bus.stall;
  assign bus.BankFSM   = state;
  assign bus.RowId     = row_id;
  assign accept        = bus.cmd_valid & bus.cmd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      row_id    <= '0;
      row_valid <= 1'b0;
      out_en    <= 1'b0;
      sync_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef AUTOPRECHARGE_EN
      auto_pre  <= 1'b0;
`endif
    end else begin
      out_en <= 1'b1;
      if (!bus.stall) begin
        sync_q <= 1'b0;
        err_q  <= 1'b0;
        case (state)
          IDLE: begin
            if (accept) begin
              case (bus.cmd)
                CMD_ACT: begin
                  sync_q    <= ~row_valid | (bus.row != row_id);
                  row_id    <= bus.row;
                  row_valid <= 1'b1;
                  timer     <= TW'(TRCD - 1);
                  state     <= ACTIVATING;
                end
                CMD_REF: begin
                  timer <= TW'(TRFC - 1);
                  state <= REFRESHING;
                end
                CMD_NOP, CMD_PRE: ;
                default: err_q <= 1'b1;
              endcase
            end
          end
          ACTIVE: begin
            if (accept) begin
              case (bus.cmd)
                CMD_RD: begin
                  state <= READ;
`ifdef AUTOPRECHARGE_EN
                  auto_pre <= 1'b0;
`endif
                end
                CMD_WR: begin
                  state <= WRITE;
`ifdef AUTOPRECHARGE_EN
                  auto_pre <= 1'b0;
`endif
                end
                CMD_PRE: begin
                  timer <= TW'(TRP - 1);
                  state <= PRECHARGING;
                end
`ifdef AUTOPRECHARGE_EN
                CMD_RDA: begin
                  state    <= READ;
                  auto_pre <= 1'b1;
                end
                CMD_WRA: begin
                  state    <= WRITE;
                  auto_pre <= 1'b1;
                end
`endif
                CMD_NOP: ;
                default: err_q <= 1'b1;
              endcase
            end
          end
          ACTIVATING: begin
            if (timer == '0) state <= ACTIVE;
            else             timer <= timer - TW'(1);
          end
          PRECHARGING: begin
            // The row address is kept for observation but no longer names an open row.
            if (timer == '0) begin
              state     <= IDLE;
              row_valid <= 1'b0;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          REFRESHING: begin
            if (timer == '0) state <= IDLE;
            else             timer <= timer - TW'(1);
          end
          READ: begin
            timer <= TW'(BURSTCYC - 1);
            state <= READDATA;
          end
          WRITE: begin
            timer <= TW'(BURSTCYC - 1);
            state <= WRITEDATA;
          end
          READDATA, WRITEDATA: begin
            if (timer == '0) begin
`ifdef AUTOPRECHARGE_EN
              if (auto_pre) begin
                timer <= TW'(TRP - 1);
                state <= PRECHARGING;
              end else begin
                state <= ACTIVE;
              end
`else
              state <= ACTIVE;
`endif
            end else begin
              timer <= timer - TW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_bank_fsm.sv
// Self-checking bench for mem_bank_fsm: directed scenarios plus random traffic against a sequence-queue model.
module tb_mem_bank_fsm;

  localparam int unsigned AW    = 17;
  localparam int unsigned P_RCD = 4;
  localparam int unsigned P_RP  = 4;
  localparam int unsigned P_RFC = 16;
  localparam int unsigned P_BL  = 4;
  localparam int unsigned VW    = 5 + AW + 3;

  localparam logic [4:0] S_IDLE = 5'b00000, S_ACTG = 5'b00001, S_ACTV = 5'b00010,
                         S_PRE  = 5'b00011, S_REFR = 5'b00100, S_RD   = 5'b01011,
                         S_RDD  = 5'b01100, S_WR   = 5'b10010, S_WRD  = 5'b10011;
  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                         C_PRE = 3'd4, C_REF = 3'd5, C_RDA = 3'd6, C_WRA = 3'd7;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  mem_bank_fsm_if #(.ADDRWIDTH(AW)) bus ();

  mem_bank_fsm #(
    .ADDRWIDTH(AW), .TRCD(P_RCD), .TRP(P_RP), .TRFC(P_RFC), .BURSTCYC(P_BL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: the bank's future is a queue of per-cycle state codes produced when a command is accepted.
  logic [4:0]    m_cur;
  logic [4:0]    m_q[$];
  logic [AW-1:0] m_row;
  logic          m_valid, m_sync, m_err, m_started;

  task automatic model_reset();
    m_cur = S_IDLE; m_q.delete(); m_row = '0;
    m_valid = 1'b0; m_sync = 1'b0; m_err = 1'b0; m_started = 1'b0;
  endtask

  function automatic logic exp_ready();
    return m_started && (m_cur == S_IDLE || m_cur == S_ACTV) && !bus.stall;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_cur, m_row, exp_ready(), m_sync & ~bus.stall, m_err & ~bus.stall};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.BankFSM, bus.RowId, bus.cmd_ready, bus.sync, bus.err};
  endfunction

  task automatic push_n(input logic [4:0] code, input int unsigned n);
    repeat (n) m_q.push_back(code);
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    logic acc;
    acc = bus.cmd_valid && exp_ready();
    if (!bus.stall) begin
      m_sync = 1'b0;
      m_err  = 1'b0;
      if (m_q.size() != 0) begin
        if (m_cur == S_PRE && m_q[0] == S_IDLE) m_valid = 1'b0;
        m_cur = m_q.pop_front();
      end else if (acc) begin
        if (m_cur == S_IDLE) begin
          case (bus.cmd)
            C_ACT: begin
              m_sync  = !m_valid || (bus.row != m_row);
              m_row   = bus.row;
              m_valid = 1'b1;
              push_n(S_ACTG, P_RCD); push_n(S_ACTV, 1);
            end
            C_REF: begin push_n(S_REFR, P_RFC); push_n(S_IDLE, 1); end
            C_NOP, C_PRE: ;
            default: m_err = 1'b1;
          endcase
        end else begin
          case (bus.cmd)
            C_RD:  begin push_n(S_RD, 1); push_n(S_RDD, P_BL); push_n(S_ACTV, 1); end
            C_WR:  begin push_n(S_WR, 1); push_n(S_WRD, P_BL); push_n(S_ACTV, 1); end
            C_PRE: begin push_n(S_PRE, P_RP); push_n(S_IDLE, 1); end
`ifdef AUTOPRECHARGE_EN
            C_RDA: begin push_n(S_RD, 1); push_n(S_RDD, P_BL); push_n(S_PRE, P_RP); push_n(S_IDLE, 1); end
            C_WRA: begin push_n(S_WR, 1); push_n(S_WRD, P_BL); push_n(S_PRE, P_RP); push_n(S_IDLE, 1); end
`endif
            C_NOP: ;
            default: m_err = 1'b1;
          endcase
        end
        if (m_q.size() != 0) m_cur = m_q.pop_front();
      end
    end
    m_started = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [AW-1:0] r, input logic s);
    @(negedge clk);
    bus.cmd_valid = v; bus.cmd = c; bus.row = r; bus.stall = s;
    #1;
  endtask

  // Asserts reset in the current cycle, checks the forced outputs, then releases on the next falling edge.
  task automatic apply_reset();
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd = C_NOP; bus.stall = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== '0) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=0", obs_vec());
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    model_step();
  endtask

  task automatic test_reset();
    @(negedge clk);
    apply_reset();
    drive(1'b0, C_NOP, '0, 1'b0);
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_rise got=%b exp=1", bus.cmd_ready);
    end
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model got=%h exp=%h", obs_vec(), exp_vec());
    end
    model_step();
  endtask

  task automatic test_act_sync();
    int nact = 0;
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, C_ACT, 17'h1A2B, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL act_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (bus.BankFSM === S_ACTG) nact++;
      if (i == 1) begin
        n_checks++;
        if (bus.sync !== 1'b1 || bus.RowId !== 17'h1A2B) begin
          n_fail++; $display("FAIL act_first_cycle sync=%b row=%h exp sync=1 row=1a2b", bus.sync, bus.RowId);
        end
      end
      model_step();
    end
    n_checks++;
    if (nact != 4 || bus.BankFSM !== S_ACTV) begin
      n_fail++; $display("FAIL act_duration cycles=%0d state=%b exp 4 then 00010", nact, bus.BankFSM);
    end
  endtask

  task automatic test_read();
    int nrd = 0, nrdd = 0, nrdy = 0;
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, C_RD, '0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL read_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (bus.BankFSM === S_RD) nrd++;
      if (bus.BankFSM === S_RDD) nrdd++;
      if (i >= 1 && i <= 5 && bus.cmd_ready !== 1'b0) nrdy++;
      model_step();
    end
    n_checks++;
    if (nrd != 1 || nrdd != 4 || nrdy != 0 || bus.BankFSM !== S_ACTV) begin
      n_fail++; $display("FAIL read_burst read=%0d data=%0d ready_hi=%0d state=%b exp 1/4/0/00010", nrd, nrdd, nrdy, bus.BankFSM);
    end
  endtask

  task automatic test_write_stall();
    int nwd = 0, nrdy = 0;
    for (int i = 0; i < 12; i++) begin
      drive(i == 0, C_WR, '0, (i >= 3 && i <= 5));
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL wstall_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (bus.BankFSM === S_WRD) nwd++;
      if (i >= 1 && i <= 8 && bus.cmd_ready !== 1'b0) nrdy++;
      model_step();
    end
    n_checks++;
    if (nwd != 7 || nrdy != 0 || bus.BankFSM !== S_ACTV) begin
      n_fail++; $display("FAIL wstall_duration data=%0d ready_hi=%0d state=%b exp 7/0/00010", nwd, nrdy, bus.BankFSM);
    end
  endtask

  task automatic test_pre_reactivate();
    for (int i = 0; i < 7; i++) begin
      drive(i == 0, C_PRE, '0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL pre_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      model_step();
    end
    for (int i = 0; i < 7; i++) begin
      drive(i == 0, C_ACT, 17'h1A2B, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL react_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        n_checks++;
        if (bus.sync !== 1'b1) begin
          n_fail++; $display("FAIL react_sync got=%b exp=1", bus.sync);
        end
      end
      model_step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, C_ACT, 17'h0F0F, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL act_in_active_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (i >= 1) begin
        n_checks++;
        if (bus.err !== (i == 1) || bus.BankFSM !== S_ACTV) begin
          n_fail++; $display("FAIL act_in_active_err cyc=%0d err=%b state=%b exp err=%0d state=00010", i, bus.err, bus.BankFSM, (i == 1));
        end
      end
      model_step();
    end
  endtask

  task automatic test_autoprecharge();
    for (int i = 0; i < 12; i++) begin
      drive(i == 0, C_RDA, '0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rda_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
`ifdef AUTOPRECHARGE_EN
      if (i == 7 || i == 10) begin
        n_checks++;
        if (bus.BankFSM !== ((i == 7) ? S_PRE : S_IDLE)) begin
          n_fail++; $display("FAIL rda_sequence cyc=%0d state=%b", i, bus.BankFSM);
        end
      end
`else
      if (i == 1) begin
        n_checks++;
        if (bus.err !== 1'b1 || bus.BankFSM !== S_ACTV) begin
          n_fail++; $display("FAIL rda_illegal err=%b state=%b exp err=1 state=00010", bus.err, bus.BankFSM);
        end
      end
`endif
      model_step();
    end
  endtask

  task automatic test_refresh_reset();
    int  nref = 0;
    logic hit = 1'b0;
    @(negedge clk);
    apply_reset();
    for (int i = 0; i < 20 && !hit; i++) begin
      drive(i == 0, C_REF, '0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL ref_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (bus.BankFSM === S_REFR) nref++;
      if (nref == 8) hit = 1'b1;
      else model_step();
    end
    n_checks++;
    if (!hit) begin
      n_fail++; $display("FAIL ref_reach_8th refreshing_cycles=%0d exp=8", nref);
    end
    apply_reset();
  endtask

  task automatic test_random();
    logic [AW-1:0] r;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 2))
        0: r = 17'h1A2B;
        1: r = 17'h0055;
        default: r = AW'($urandom);
      endcase
      drive(($urandom_range(0, 2) != 0), 3'($urandom), r, ($urandom_range(0, 3) == 0));
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      model_step();
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd = C_NOP; bus.row = '0; bus.stall = 1'b0;
    model_reset();
    test_reset();
    test_act_sync();
    test_read();
    test_write_stall();
    test_pre_reactivate();
    test_autoprecharge();
    test_refresh_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
